decode_issue_ctrl: RTL and testbench

- Sequences the decode stage between fetch and execute.
- Holds each fetched instruction and its PC, and drives the instruction to the external immediate extractor. It captures the returned immediate in the same cycle and issues {inst, pc, imm} downstream over a valid/ready handshake.
- Contains a 2-entry skid buffer, so fetch and execute are decoupled without a combinational ready path from execute to fetch.
- Supports pipeline flush from branch/jump resolution and flags unknown opcodes.

---
 rtl/decode_issue_ctrl_if.sv | 46 ++++
 rtl/decode_issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// decode_issue_ctrl_if
// Bundles the fetch-side, extractor-side and execute-side signals of the
// decode/issue stage. The design uses the slave modport; whoever drives the
// stage (fetch, extractor, execute, or a bench) uses the master modport.
//
// Signals:
//   in_valid/in_ready   fetch handshake
//   in_inst/in_pc       fetched instruction word and its PC
//   ext_inst/ext_imm    immediate extractor request/response (combinational)
//   flush               discard all held entries (taken branch/jump)
//   out_valid/out_ready execute handshake
//   out_inst/out_pc     issued instruction and PC
//   out_imm/out_illegal issued immediate and unknown-opcode flag
//   stall_cnt           output stall cycle counter (CNT_W bits)
// ---------------------------------------------------------------------------
interface decode_issue_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic [31:0]      ext_inst;
  logic [31:0]      ext_imm;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [31:0]      out_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, in_inst, in_pc, ext_imm, flush, out_ready,
    output in_ready, ext_inst, out_valid, out_inst, out_pc, out_imm,
           out_illegal, stall_cnt
  );

  modport master (
    output in_valid, in_inst, in_pc, ext_imm, flush, out_ready,
    input  in_ready, ext_inst, out_valid, out_inst, out_pc, out_imm,
           out_illegal, stall_cnt
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// ---------------------------------------------------------------------------
// decode_issue_ctrl
// Decode stage sequencer between fetch and execute. Each accepted instruction
// is captured together with its PC, the immediate returned by the external
// extractor in the same cycle, and an unknown-opcode flag. Entries are issued
// in order over a valid/ready handshake. A 2-entry skid buffer (output
// register O plus skid register S) keeps in_ready independent of out_ready.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   decode_issue_ctrl_if.slave (fetch, extractor, execute, flush,
//         stall counter)
//
// Parameters:
//   NOP_INST  value of out_inst whenever no valid entry is held
//   CNT_W     stall counter width
//
// Build option:
//   DECODE_STALL_CNT_EN  when defined, stall_cnt counts cycles with
//                        out_valid && !out_ready (saturating, cleared by rst
//                        only); otherwise stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module decode_issue_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_issue_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e        state_r;
  logic [31:0] o_inst_r;
  logic [31:0] o_pc_r;
  logic [31:0] o_imm_r;
  logic        o_ill_r;
  logic [31:0] s_inst_r;
  logic [31:0] s_pc_r;
  logic [31:0] s_imm_r;
  logic        s_ill_r;

  logic        o_valid_s;
  logic        s_valid_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        issue_s;
  logic        new_ill_s;

  // Unknown-opcode check for the 9 supported base opcodes.
  function automatic logic illegal_op(input logic [6:0] op);
    logic ill;
    case (op)
      7'b0110011, 7'b0000011, 7'b1100111,
      7'b0010011, 7'b0100011, 7'b1100011,
      7'b0110111, 7'b0010111, 7'b1101111: ill = 1'b0;
      default:                            ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Handshake decode; in_ready looks only at held state, flush and rst.
  always_comb begin
    o_valid_s  = (state_r == ONE) || (state_r == TWO);
    s_valid_s  = (state_r == TWO);
    in_ready_s = !s_valid_s && !bus.flush && !rst;
    accept_s   = bus.in_valid && in_ready_s;
    issue_s    = o_valid_s && bus.out_ready;
    new_ill_s  = illegal_op(bus.in_inst[6:0]);
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.ext_inst    = bus.in_inst;
  assign bus.out_valid   = o_valid_s;
  assign bus.out_inst    = o_inst_r;
  assign bus.out_pc      = o_pc_r;
  assign bus.out_imm     = o_imm_r;
  assign bus.out_illegal = o_ill_r;

  // Occupancy FSM with O/S entry registers. O fields are rewritten only on
  // issue or when O is empty, so O stays stable while execute stalls.
  // When O empties, inst/imm/illegal return to their idle values but the
  // last PC is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= EMPTY;
      o_inst_r <= NOP_INST;
      o_pc_r   <= 32'd0;
      o_imm_r  <= 32'd0;
      o_ill_r  <= 1'b0;
      s_inst_r <= NOP_INST;
      s_pc_r   <= 32'd0;
      s_imm_r  <= 32'd0;
      s_ill_r  <= 1'b0;
    end else if (bus.flush) begin
      state_r  <= EMPTY;
      o_inst_r <= NOP_INST;
      o_imm_r  <= 32'd0;
      o_ill_r  <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r  <= ONE;
            o_inst_r <= bus.in_inst;
            o_pc_r   <= bus.in_pc;
            o_imm_r  <= bus.ext_imm;
            o_ill_r  <= new_ill_s;
          end
        end
        ONE: begin
          if (issue_s && accept_s) begin
            o_inst_r <= bus.in_inst;
            o_pc_r   <= bus.in_pc;
            o_imm_r  <= bus.ext_imm;
            o_ill_r  <= new_ill_s;
          end else if (issue_s) begin
            state_r  <= EMPTY;
            o_inst_r <= NOP_INST;
            o_imm_r  <= 32'd0;
            o_ill_r  <= 1'b0;
          end else if (accept_s) begin
            state_r  <= TWO;
            s_inst_r <= bus.in_inst;
            s_pc_r   <= bus.in_pc;
            s_imm_r  <= bus.ext_imm;
            s_ill_r  <= new_ill_s;
          end
        end
        TWO: begin
          // in_ready is low here, so only the skid entry can move.
          if (issue_s) begin
            state_r  <= ONE;
            o_inst_r <= s_inst_r;
            o_pc_r   <= s_pc_r;
            o_imm_r  <= s_imm_r;
            o_ill_r  <= s_ill_r;
          end
        end
        default: begin
          state_r  <= EMPTY;
          o_inst_r <= NOP_INST;
          o_imm_r  <= 32'd0;
          o_ill_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of cycles where execute holds off a valid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (o_valid_s && !bus.out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_issue_ctrl
// Self-checking bench for decode_issue_ctrl. A queue-based reference model
// (at most two entries, oldest at the head) predicts every output each cycle.
// Directed sequences follow the test plan, then randomized traffic with
// flushes and resets runs against the same model.
// ---------------------------------------------------------------------------
module tb_decode_issue_ctrl;

  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [6:0]  LEGAL [9] = '{7'b0110011, 7'b0000011, 7'b1100111,
                                        7'b0010011, 7'b0100011, 7'b1100011,
                                        7'b0110111, 7'b0010111, 7'b1101111};

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        ill;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_cnt;

  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  decode_issue_ctrl #(.NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Extractor model: I-type immediate, sign-extended.
  assign bus.ext_imm = {{20{bus.ext_inst[31]}}, bus.ext_inst[31:20]};

  function automatic logic [31:0] sext_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic is_illegal(input logic [6:0] op);
    foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic r);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
    rst           = r;
  endtask

  // One clock: compare all outputs to the model at negedge, then advance the
  // model with this cycle's inputs. Returns 1 time unit after the posedge.
  task automatic cycle();
    int   sz;
    logic acc, iss, fl, rdy, r;
    ent_t e;
    @(negedge clk);
    sz  = q.size();
    fl  = bus.flush;
    rdy = bus.out_ready;
    r   = rst;
    acc = bus.in_valid && (sz < 2) && !fl && !r;
    iss = (sz > 0) && rdy;
    check("in_ready",    32'(bus.in_ready),    32'((sz < 2) && !fl && !r));
    check("ext_inst",    bus.ext_inst,         bus.in_inst);
    check("out_valid",   32'(bus.out_valid),   32'(sz > 0));
    check("out_inst",    bus.out_inst,         (sz > 0) ? q[0].inst : NOP);
    check("out_pc",      bus.out_pc,           (sz > 0) ? q[0].pc : m_pc);
    check("out_imm",     bus.out_imm,          (sz > 0) ? q[0].imm : 32'd0);
    check("out_illegal", 32'(bus.out_illegal), 32'((sz > 0) ? q[0].ill : 1'b0));
    check("stall_cnt",   32'(bus.stall_cnt),   32'(m_cnt));
    e.inst = bus.in_inst;
    e.pc   = bus.in_pc;
    e.imm  = sext_i(bus.in_inst);
    e.ill  = is_illegal(bus.in_inst[6:0]);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_pc  = 32'd0;
      m_cnt = 0;
    end else begin
`ifdef DECODE_STALL_CNT_EN
      if ((sz > 0) && !rdy && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
`endif
      if (fl) begin
        q.delete();
      end else begin
        if (iss) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    if (q.size() > 0) m_pc = q[0].pc;
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(9, 0) < 8) w[6:0] = LEGAL[$urandom_range(8, 0)];
    return w;
  endfunction

  task automatic do_reset();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    q.delete();
    m_pc  = 32'd0;
    m_cnt = 0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    do_reset();

    // Single instruction, 1-cycle latency, fetch keeps flowing.
    drive(1'b1, 32'hFFF0_0093, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    cycle();
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_imm",   bus.out_imm,        32'hFFFF_FFFF);
    bus.in_valid = 1'b0;
    cycle();

    // Stall with A then B: skid fills, in_ready drops, order preserved.
    drive(1'b1, 32'h0000_0033, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h0040_0013, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h0080_0013, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t2_hold_pc", bus.out_pc,         32'h0000_0000);
    check("t2_ready0",  32'(bus.in_ready),  32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("t2_b_pc", bus.out_pc, 32'h0000_0004);
    cycle();
    check("t2_ready1", 32'(bus.in_ready), 32'd1);

    // Flush while full: nothing survives, flushed-cycle fetch dropped.
    drive(1'b1, 32'h0000_0033, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    cycle();
    bus.in_pc = 32'h0000_0014;
    cycle();
    drive(1'b1, 32'h0000_0013, 32'h0000_0018, 1'b1, 1'b1, 1'b0);
    cycle();
    check("t3_valid", 32'(bus.out_valid), 32'd0);
    check("t3_inst",  bus.out_inst,       NOP);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    cycle();

    // Unknown opcode followed by a legal one.
    drive(1'b1, 32'h0000_007F, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
    cycle();
    check("t4_ill", 32'(bus.out_illegal), 32'd1);
    bus.in_inst = 32'h0000_0033;
    bus.in_pc   = 32'h0000_0024;
    cycle();
    check("t4_legal", 32'(bus.out_illegal), 32'd0);
    bus.in_valid = 1'b0;
    cycle();

    // Reset while full.
    drive(1'b1, 32'h0000_0033, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    cycle();
    bus.in_pc = 32'h0000_0034;
    cycle();
    drive(1'b1, 32'h0000_0033, 32'h0000_0038, 1'b0, 1'b0, 1'b1);
    cycle();
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    cycle();

    // Long stall: counter saturates (or stays zero without the feature).
    drive(1'b1, 32'h0000_0033, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
`ifdef DECODE_STALL_CNT_EN
    check("t6_sat", 32'(bus.stall_cnt), 32'd15);
`else
    check("t6_zero", 32'(bus.stall_cnt), 32'd0);
`endif
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(9, 0) < 7, rand_inst(), $urandom,
            $urandom_range(9, 0) < 6, $urandom_range(99, 0) < 8,
            $urandom_range(99, 0) < 2);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
